// File: rtl/uop_decode_queue.sv
// Decode-to-rename micro-op queue: compacts up to IN_W valid slots per cycle into a
// circular buffer and presents up to OUT_W oldest entries with variable consumption.
module uop_decode_queue #(
  parameter int unsigned UOP_W = 128,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [IN_W*UOP_W-1:0]        in_uop,
  input  logic [IN_W-1:0]              in_valid,
  output logic                         in_ready,
  output logic                         pause_req,
  output logic [OUT_W*UOP_W-1:0]       out_uop,
  output logic [OUT_W-1:0]             out_valid,
  input  logic [$clog2(OUT_W+1)-1:0]   out_accept,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [UOP_W-1:0] mem_q [DEPTH];

  logic             enq;
  logic [IN_W-1:0]  wr_en;
  logic [PtrW-1:0]  wr_idx [IN_W];
  int unsigned      n_in;
  int unsigned      n_enq;
  int unsigned      n_avail;
  int unsigned      n_out;

  // Space check uses registered count only, so out_accept never reaches in_ready.
  assign in_ready  = (CntW'(DEPTH) - count_q) >= CntW'(IN_W);
  assign pause_req = !in_ready;
  assign count     = count_q;

  // Slot i lands at tail plus the number of valid slots below it.
  always_comb begin
    enq  = in_ready && (|in_valid) && !flush;
    n_in = 0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      wr_idx[i] = tail_q + PtrW'(n_in);
      wr_en[i]  = enq && in_valid[i];
      if (in_valid[i]) begin
        n_in = n_in + 1;
      end
    end
    n_enq = enq ? n_in : 0;
  end

  always_comb begin
    n_avail = (count_q > CntW'(OUT_W)) ? OUT_W : 32'(count_q);
    n_out   = (32'(out_accept) < n_avail) ? 32'(out_accept) : n_avail;
    head_d  = head_q + PtrW'(n_out);
    tail_d  = tail_q + PtrW'(n_enq);
    count_d = count_q + CntW'(n_enq) - CntW'(n_out);
  end

  always_comb begin
    out_valid = '0;
    out_uop   = '0;
    for (int unsigned j = 0; j < OUT_W; j++) begin
      out_valid[j] = CntW'(j) < count_q;
      if (out_valid[j]) begin
        out_uop[j*UOP_W +: UOP_W] = mem_q[head_q + PtrW'(j)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; count gates every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= in_uop[i*UOP_W +: UOP_W];
      end
    end
  end

endmodule
